input_frame_loader: RTL and testbench
=====================================

// Module: input_frame_loader
// PURPOSE
// Upstream feeder for the RBM Main block. Accepts a serial pixel stream (one
// greyscale pixel per beat, valid/ready), binarises each pixel against a
// threshold and packs a full frame into the 1-bit-per-element InputDataPort
// vector. Double-buffered: the next frame fills while Main is still
// processing the current one. Drives Main's data_valid and consumes its finish.
// PARAMETERS
// input_dim     784  pixels per frame (64 for sparse builds); Main's input_dim
// pixel_bits    8    width of one incoming pixel
// threshold     128  binarisation: bit = (pixel >= threshold)
// count_bits    16   width of frame_count
// PORTS
// clock         in   1                      rising-edge clock
// reset         in   1                      asynchronous, active-low reset
// pixel_in      in   pixel_bits             pixel value
// pixel_sof     in   1                      marks pixel 0 of a frame (qualified by valid)
// pixel_valid   in   1                      pixel_in/pixel_sof valid
// pixel_ready   out  1                      loader can accept a pixel this cycle
// data_valid    out  1                      to Main: InputDataPort holds a full frame
// InputDataPort out  input_dim              packed frame; element i at bit i
// finish        in   1                      from Main: current frame consumed
// frame_count   out  count_bits             frames handed to Main, wraps at 2^count_bits
// frame_err     out  1                      1-cycle pulse: partial frame discarded
// BEHAVIOUR
// Reset (reset==0, async): every output 0, all counters and buffers 0, fill
//   side FILL with pix_cnt=0, present side EMPTY. pixel_ready is 1 on the first edge after release.
// Accept: beat = pixel_valid & pixel_ready. pixel_ready = (fill_state==FILL).
//   On a beat: fill_buf[pix_cnt] <= (pixel_in >= threshold) (unsigned compare), pix_cnt++.
//   On the beat with pix_cnt==input_dim-1: pix_cnt<=0, fill_state<=FULL.
// SOF: beat with pixel_sof=1 and pix_cnt!=0 -> discard partial frame; this pixel
//   is written as element 0, pix_cnt<=1, frame_err pulses next cycle.
//   pixel_sof=1 at pix_cnt==0 is normal. pix_cnt==0 without sof is accepted as element 0.
// Fill FSM: FILL -> FULL on last pixel; FULL -> FILL on handoff (same edge).
// Present FSM (EMPTY, PRESENT, GAP):
//   EMPTY   : if fill_state==FULL -> handoff: InputDataPort<=fill_buf,
//             frame_count++, fill_state<=FILL, go PRESENT.
//   PRESENT : data_valid=1. InputDataPort is held constant. If finish==1 -> GAP.
//   GAP     : data_valid=0. Stay while finish==1. When finish==0 -> EMPTY.
//   The handoff decision in EMPTY is made on the edge after GAP exits.
// Latency: last pixel accepted at edge N -> fill FULL after N, handoff at N+1,
//   data_valid=1 from N+1 (visible in cycle N+1..) when present side was EMPTY.
// Back-pressure: while fill side FULL and present side busy, pixel_ready=0;
//   at most one complete frame waits in addition to the one at Main.
// Simultaneous: finish while fill FULL -> GAP first, never skip the low
//   data_valid cycle; Main always sees data_valid fall between frames.
// data_valid is a registered output; no combinational path from pixel_* or finish to outputs except pixel_ready.
// finish outside PRESENT is ignored. frame_count wraps to 0 after all-ones.
// Mid-operation reset: frame in fill_buf and at Main discarded, data_valid drops asynchronously.
// TESTING
// 1 Stream 784 pixels, pixel k = (k%2)?200:50, Main idle -> data_valid rises 1 cycle
//   after last beat, InputDataPort = {392{2'b10}}, frame_count=1.
// 2 Threshold edges: pixels 127,128,255,0 as elements 0..3 -> bits[3:0]=4'b0110.
// 3 Back-to-back frames A,B with finish held 0 -> B fills, pixel_ready=0 after
//   B's last pixel; finish pulse -> data_valid 0 for >=1 cycle then B presented, frame_count=2.
// 4 sof at pixel 300 of frame -> frame_err 1-cycle pulse, the following 784 pixels form
//   the frame, no data_valid before then.
// 5 finish held high 5 cycles -> data_valid stays 0 until finish low; queued frame then presented.
// 6 reset low mid-fill and during PRESENT -> all outputs 0 immediately; next full frame loads cleanly.

Source files
------------

// File: rtl/input_frame_loader.sv
// ---------------------------------------------------------------------------
// input_frame_loader
// Collects a serial greyscale pixel stream (valid/ready), binarises each pixel
// against a threshold and packs one frame into a 1-bit-per-element vector for
// the RBM Main block. Double-buffered: a fill buffer collects the next frame
// while the present register holds the frame Main is working on.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   pixel_in_i          pixel value (PIXEL_BITS wide)
//   pixel_sof_i         marks pixel 0 of a frame (qualified by pixel_valid_i)
//   pixel_valid_i       pixel_in_i / pixel_sof_i valid
//   pixel_ready_o       loader accepts a pixel this cycle
//   data_valid_o        input_data_port_o holds a full frame for Main
//   input_data_port_o   packed frame, element i at bit i
//   finish_i            Main has consumed the presented frame
//   frame_count_o       frames handed to Main (wraps)
//   frame_err_o         one-cycle pulse when a partial frame is discarded
// ---------------------------------------------------------------------------
module input_frame_loader #(
    parameter int unsigned INPUT_DIM  = 784,
    parameter int unsigned PIXEL_BITS = 8,
    parameter int unsigned THRESHOLD  = 128,
    parameter int unsigned COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PIXEL_BITS-1:0] pixel_in_i,
    input  logic                  pixel_sof_i,
    input  logic                  pixel_valid_i,
    output logic                  pixel_ready_o,
    output logic                  data_valid_o,
    output logic [INPUT_DIM-1:0]  input_data_port_o,
    input  logic                  finish_i,
    output logic [COUNT_BITS-1:0] frame_count_o,
    output logic                  frame_err_o
);

    localparam int unsigned CNT_W = (INPUT_DIM > 1) ? $clog2(INPUT_DIM) : 1;
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(INPUT_DIM - 1);
    localparam logic [PIXEL_BITS-1:0] THR      = PIXEL_BITS'(THRESHOLD);

    typedef enum logic {
        FILL,
        FULL
    } fill_state_e;

    typedef enum logic [1:0] {
        EMPTY,
        PRESENT,
        GAP
    } pres_state_e;

    fill_state_e            fill_state_q, fill_state_d;
    pres_state_e            pres_state_q, pres_state_d;
    logic [CNT_W-1:0]       pix_cnt_q, pix_cnt_d;
    logic [INPUT_DIM-1:0]   fill_buf_q, fill_buf_d;
    logic [INPUT_DIM-1:0]   port_q, port_d;
    logic [COUNT_BITS-1:0]  count_q, count_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    logic                   beat;
    logic                   pix_bit;

    assign beat    = pixel_valid_i & ready_q;
    assign pix_bit = (pixel_in_i >= THR);

    // Next-state logic for the fill side and the present side
    always_comb begin
        fill_state_d = fill_state_q;
        pres_state_d = pres_state_q;
        pix_cnt_d    = pix_cnt_q;
        fill_buf_d   = fill_buf_q;
        port_d       = port_q;
        count_d      = count_q;
        err_d        = 1'b0;

        // Fill side: beats only occur in FILL, handoff only in FULL
        if (beat) begin
            if (pixel_sof_i && (pix_cnt_q != '0)) begin
                // Early SOF: drop the partial frame, restart at element 0
                fill_buf_d    = '0;
                fill_buf_d[0] = pix_bit;
                pix_cnt_d     = CNT_W'(1);
                err_d         = 1'b1;
            end else begin
                fill_buf_d[pix_cnt_q] = pix_bit;
                if (pix_cnt_q == LAST_IDX) begin
                    pix_cnt_d    = '0;
                    fill_state_d = FULL;
                end else begin
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                end
            end
        end

        // Present side: GAP guarantees data_valid falls between frames
        case (pres_state_q)
            EMPTY: begin
                if (fill_state_q == FULL) begin
                    port_d       = fill_buf_q;
                    count_d      = count_q + COUNT_BITS'(1);
                    fill_state_d = FILL;
                    pres_state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (finish_i) begin
                    pres_state_d = GAP;
                end
            end
            GAP: begin
                if (!finish_i) begin
                    pres_state_d = EMPTY;
                end
            end
            default: begin
                pres_state_d = EMPTY;
            end
        endcase

        ready_d = (fill_state_d == FILL);
        valid_d = (pres_state_d == PRESENT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_state_q <= FILL;
            pres_state_q <= EMPTY;
            pix_cnt_q    <= '0;
            fill_buf_q   <= '0;
            port_q       <= '0;
            count_q      <= '0;
            ready_q      <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            fill_state_q <= fill_state_d;
            pres_state_q <= pres_state_d;
            pix_cnt_q    <= pix_cnt_d;
            fill_buf_q   <= fill_buf_d;
            port_q       <= port_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign pixel_ready_o     = ready_q;
    assign data_valid_o      = valid_q;
    assign input_data_port_o = port_q;
    assign frame_count_o     = count_q;
    assign frame_err_o       = err_q;

endmodule

// File: tb/tb_input_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_input_frame_loader
// Scoreboard bench: each complete frame's expected packed vector is queued as
// it is driven and compared when data_valid rises. All sampling happens on the
// falling edge inside tick(), which also runs the output monitor.
// ---------------------------------------------------------------------------
module tb_input_frame_loader;

    localparam int unsigned DIM = 784;
    localparam int unsigned PB  = 8;
    localparam int unsigned CB  = 16;

    logic           clk;
    logic           rst_n;
    logic [PB-1:0]  pixel_in;
    logic           pixel_sof;
    logic           pixel_valid;
    logic           pixel_ready;
    logic           data_valid;
    logic [DIM-1:0] data_port;
    logic           finish;
    logic [CB-1:0]  frame_count;
    logic           frame_err;

    input_frame_loader #(
        .INPUT_DIM (DIM),
        .PIXEL_BITS(PB),
        .THRESHOLD (128),
        .COUNT_BITS(CB)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pixel_in_i       (pixel_in),
        .pixel_sof_i      (pixel_sof),
        .pixel_valid_i    (pixel_valid),
        .pixel_ready_o    (pixel_ready),
        .data_valid_o     (data_valid),
        .input_data_port_o(data_port),
        .finish_i         (finish),
        .frame_count_o    (frame_count),
        .frame_err_o      (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int             checks;
    int             failures;
    logic [DIM-1:0] sb_q[$];
    logic [DIM-1:0] held_exp;
    logic           dv_prev;
    int             mon_cnt;
    int             rises;
    int             err_cnt;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle; sample on the falling edge and run the monitor
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            dv_prev = 1'b0;
            mon_cnt = 0;
        end else begin
            if (data_valid && !dv_prev) begin
                rises++;
                mon_cnt++;
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    held_exp = sb_q.pop_front();
                    chk("frame", data_port, held_exp);
                    chk("count", frame_count, CB'(mon_cnt));
                end
            end
            if (!data_valid && dv_prev) begin
                chk("held", data_port, held_exp);
            end
            if (frame_err) err_cnt++;
            dv_prev = data_valid;
        end
    endtask

    function automatic logic [PB-1:0] pix(input int kind, input int k);
        if (kind == 0) return (k % 2 != 0) ? 8'd200 : 8'd50;
        if (kind == 1 && k < 4) begin
            case (k)
                0: return 8'd127;
                1: return 8'd128;
                2: return 8'd255;
                default: return 8'd0;
            endcase
        end
        return PB'((k * 37 + kind * 91 + (k / 7) * 13) % 256);
    endfunction

    // Drive one pixel and return on the falling edge after the beat
    task automatic send_px(input logic [PB-1:0] v, input logic sof);
        int budget;
        pixel_in    = v;
        pixel_sof   = sof;
        pixel_valid = 1'b1;
        budget      = 5000;
        while (!pixel_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("ready_timeout", 0, 1);
        tick();
    endtask

    task automatic send_frame(input int kind);
        logic [DIM-1:0] e;
        for (int k = 0; k < DIM; k++) e[k] = (pix(kind, k) >= 8'd128);
        sb_q.push_back(e);
        for (int k = 0; k < DIM; k++) send_px(pix(kind, k), k == 0);
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
    endtask

    // Finish pulse from an idle-ish present side; returns with present side EMPTY
    task automatic release_frame();
        finish = 1'b1;
        tick();
        chk("gap_dv", data_valid, 0);
        finish = 1'b0;
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_dv"}, data_valid, 0);
        chk({tag, "_rdy"}, pixel_ready, 0);
        chk({tag, "_port"}, data_port, 0);
        chk({tag, "_cnt"}, frame_count, 0);
        chk({tag, "_err"}, frame_err, 0);
    endtask

    initial begin
        int r0;
        int e0;
        checks      = 0;
        failures    = 0;
        dv_prev     = 1'b0;
        mon_cnt     = 0;
        rises       = 0;
        err_cnt     = 0;
        held_exp    = '0;
        rst_n       = 1'b0;
        pixel_in    = '0;
        pixel_sof   = 1'b0;
        pixel_valid = 1'b0;
        finish      = 1'b0;

        // Reset state
        tick();
        tick();
        check_outputs_zero("rst");
        rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", pixel_ready, 1);

        // 1: alternating frame, latency and packing
        send_frame(0);
        chk("t1_lat_dv0", data_valid, 0);
        chk("t1_lat_rdy0", pixel_ready, 0);
        tick();
        chk("t1_lat_dv1", data_valid, 1);
        chk("t1_pattern", data_port, {392{2'b10}});
        chk("t1_count", frame_count, 1);
        chk("t1_no_err", err_cnt, 0);
        release_frame();

        // 2: threshold edges
        send_frame(1);
        tick();
        chk("t2_dv", data_valid, 1);
        chk("t2_bits", data_port[3:0], 4'b0110);
        release_frame();

        // 3: back-to-back frames, back-pressure, gap between frames
        send_frame(2);
        send_frame(3);
        tick();
        tick();
        chk("t3_rdy_bp", pixel_ready, 0);
        chk("t3_dv_a", data_valid, 1);
        r0 = rises;
        finish = 1'b1;
        tick();
        chk("t3_gap0", data_valid, 0);
        finish = 1'b0;
        tick();
        chk("t3_gap1", data_valid, 0);
        tick();
        chk("t3_b_dv", data_valid, 1);
        chk("t3_b_rise", rises, r0 + 1);
        chk("t3_b_rdy", pixel_ready, 1);
        release_frame();

        // 4: SOF at pixel 300 discards the partial frame
        e0 = err_cnt;
        r0 = rises;
        for (int k = 0; k < 300; k++) send_px(pix(4, k), k == 0);
        pixel_valid = 1'b0;
        chk("t4_partial_dv", data_valid, 0);
        send_frame(5);
        chk("t4_err_pulse", err_cnt, e0 + 1);
        chk("t4_no_early_dv", rises, r0);
        tick();
        chk("t4_dv", data_valid, 1);
        chk("t4_err_once", err_cnt, e0 + 1);
        release_frame();

        // 5: finish held high, queued frame presented after it drops
        send_frame(6);
        send_frame(7);
        tick();
        finish = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_held_dv", data_valid, 0);
        end
        finish = 1'b0;
        tick();
        chk("t5_exit_dv", data_valid, 0);
        r0 = rises;
        tick();
        chk("t5_q_dv", data_valid, 1);
        chk("t5_q_rise", rises, r0 + 1);
        chk("t5_count", frame_count, 7);
        release_frame();

        // 6: reset mid-fill and during PRESENT
        for (int k = 0; k < 100; k++) send_px(pix(8, k), k == 0);
        pixel_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("t6_fill");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_rdy", pixel_ready, 1);
        send_frame(9);
        tick();
        chk("t6_dv", data_valid, 1);
        chk("t6_cnt1", frame_count, 1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("t6_pres");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(10);
        tick();
        chk("t6_clean_dv", data_valid, 1);
        chk("t6_clean_cnt", frame_count, 1);
        release_frame();

        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
